fp_add_sub_pipe: RTL and testbench

Parametrised, pipelined IEEE-754 binary floating-point adder/subtractor with valid/ready handshakes on both sides.
- Format widths are configurable; defaults give single precision.
- Performs full normalisation and round-to-nearest-even, handles subnormals and special values, and reports exception flags.
- Sits in the FP ALU datapath as the add/sub execution unit, fed by the operand issue stage and drained by result writeback.

---
 rtl/fp_add_sub_pipe_if.sv | 28 ++
 rtl/fp_add_sub_pipe.sv | 240 ++++++++++++++++++++++++
 tb/tb_fp_add_sub_pipe.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_sub_pipe_if.sv
// Operand/result handshake bundle for the pipelined FP add/sub unit.
interface fp_add_sub_pipe_if #(
    parameter int unsigned W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_invalid;
    logic         flag_overflow;
    logic         flag_inexact;

    // Issue/writeback side: drives operands, consumes results.
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, flag_invalid, flag_overflow, flag_inexact
    );

    // Execution unit side.
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, flag_invalid, flag_overflow, flag_inexact
    );
endinterface

// File: rtl/fp_add_sub_pipe.sv
// Three-stage IEEE-754 adder/subtractor: align, add + LZC, normalise/round/pack.
module fp_add_sub_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic             clk,
    input  logic             reset,
    fp_add_sub_pipe_if.slave bus
);
    localparam int unsigned W   = 1 + EXP_W + MAN_W;
    localparam int unsigned SW  = MAN_W + 4;            // hidden, fraction, guard, round, sticky
    localparam int unsigned SHW = $clog2(SW + 1);
    localparam int unsigned LZW = $clog2(SW + 1);
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, (MAN_W-1)'(0)};

    logic advance;
    logic s1_valid, s2_valid, out_valid_q;
    logic [W-1:0] result_q;
    logic inv_q, ovf_q, inex_q;

    assign advance           = !out_valid_q || bus.out_ready;
    assign bus.in_ready      = advance;
    assign bus.out_valid     = out_valid_q;
    assign bus.result        = result_q;
    assign bus.flag_invalid  = inv_q;
    assign bus.flag_overflow = ovf_q;
    assign bus.flag_inexact  = inex_q;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic a_sign, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, swap;

    assign a_sign = bus.a[W-1];
    assign a_exp  = bus.a[W-2:MAN_W];
    assign a_frac = bus.a[MAN_W-1:0];
    assign b_sign = bus.b[W-1] ^ bus.sub;
    assign b_exp  = bus.b[W-2:MAN_W];
    assign b_frac = bus.b[MAN_W-1:0];
    assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
    assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
    assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
    assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
    assign a_snan = a_nan && !a_frac[MAN_W-1];
    assign b_snan = b_nan && !b_frac[MAN_W-1];
    assign swap   = bus.b[W-2:0] > bus.a[W-2:0];

    logic x_sign;
    logic [EXP_W-1:0] x_exp_raw, y_exp_raw, x_exp, y_exp, diff;
    logic [MAN_W-1:0] x_frac, y_frac;
    logic [SW-1:0] x_sig, y_sig, y_align;
    logic [SHW-1:0] sh;
    logic [2*SW-1:0] y_wide;

    // Order by magnitude so the subtraction never goes negative, then align Y with sticky.
    always_comb begin
        x_sign    = swap ? b_sign : a_sign;
        x_exp_raw = swap ? b_exp  : a_exp;
        y_exp_raw = swap ? a_exp  : b_exp;
        x_frac    = swap ? b_frac : a_frac;
        y_frac    = swap ? a_frac : b_frac;
        x_exp     = (x_exp_raw == '0) ? EXP_W'(1) : x_exp_raw;
        y_exp     = (y_exp_raw == '0) ? EXP_W'(1) : y_exp_raw;
        x_sig     = {x_exp_raw != '0, x_frac, 3'b000};
        y_sig     = {y_exp_raw != '0, y_frac, 3'b000};
        diff      = x_exp - y_exp;
        sh        = (32'(diff) >= SW) ? SHW'(SW) : SHW'(diff);
        y_wide    = {y_sig, SW'(0)} >> sh;
        y_align   = y_wide[2*SW-1:SW] | SW'(|y_wide[SW-1:0]);
    end

    logic spec, spec_inv;
    logic [W-1:0] spec_res;

    // Special-value result, resolved by priority: NaN, inf-inf, inf+finite.
    always_comb begin
        spec     = 1'b0;
        spec_inv = 1'b0;
        spec_res = '0;
        if (a_nan || b_nan) begin
            spec     = 1'b1;
            spec_inv = a_snan || b_snan;
            spec_res = QNAN;
        end else if (a_inf && b_inf && (a_sign != b_sign)) begin
            spec     = 1'b1;
            spec_inv = 1'b1;
            spec_res = QNAN;
        end else if (a_inf) begin
            spec     = 1'b1;
            spec_res = {a_sign, EXP_ONES, MAN_W'(0)};
        end else if (b_inf) begin
            spec     = 1'b1;
            spec_res = {b_sign, EXP_ONES, MAN_W'(0)};
        end
    end

    logic s1_sign, s1_sub, s1_spec, s1_spec_inv;
    logic [EXP_W-1:0] s1_exp;
    logic [SW-1:0] s1_sig_x, s1_sig_y;
    logic [W-1:0] s1_spec_res;

    // S1 register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_sub      <= 1'b0;
            s1_exp      <= '0;
            s1_sig_x    <= '0;
            s1_sig_y    <= '0;
            s1_spec     <= 1'b0;
            s1_spec_inv <= 1'b0;
            s1_spec_res <= '0;
        end else if (advance) begin
            s1_valid    <= bus.in_valid;
            s1_sign     <= x_sign;
            s1_sub      <= a_sign ^ b_sign;
            s1_exp      <= x_exp;
            s1_sig_x    <= x_sig;
            s1_sig_y    <= y_align;
            s1_spec     <= spec;
            s1_spec_inv <= spec_inv;
            s1_spec_res <= spec_res;
        end
    end

    // ---------------- S2: add/subtract, leading-zero count ----------------
    logic [SW:0] sum;
    logic [LZW-1:0] lz;

    // Magnitude sum and leading zeros of the non-carry part.
    always_comb begin
        sum = s1_sub ? ({1'b0, s1_sig_x} - {1'b0, s1_sig_y})
                     : ({1'b0, s1_sig_x} + {1'b0, s1_sig_y});
        lz  = LZW'(SW);
        for (int unsigned i = 0; i < SW; i++) begin
            if (sum[i]) lz = LZW'(SW - 1 - i);
        end
    end

    logic s2_sign, s2_sub, s2_spec, s2_spec_inv;
    logic [EXP_W-1:0] s2_exp;
    logic [SW:0] s2_sum;
    logic [LZW-1:0] s2_lz;
    logic [W-1:0] s2_spec_res;

    // S2 register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid    <= 1'b0;
            s2_sign     <= 1'b0;
            s2_sub      <= 1'b0;
            s2_exp      <= '0;
            s2_sum      <= '0;
            s2_lz       <= '0;
            s2_spec     <= 1'b0;
            s2_spec_inv <= 1'b0;
            s2_spec_res <= '0;
        end else if (advance) begin
            s2_valid    <= s1_valid;
            s2_sign     <= s1_sign;
            s2_sub      <= s1_sub;
            s2_exp      <= s1_exp;
            s2_sum      <= sum;
            s2_lz       <= lz;
            s2_spec     <= s1_spec;
            s2_spec_inv <= s1_spec_inv;
            s2_spec_res <= s1_spec_res;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    int unsigned lim, shl;
    logic [EXP_W:0] e_n, e_r;
    logic [SW-1:0] m_n;
    logic rnd_up, lost, ovf, z_sign;
    logic [MAN_W+1:0] mant_r;
    logic [MAN_W:0] mant_f;
    logic [EXP_W-1:0] exp_p;
    logic [W-1:0] res_n;
    logic inv_n, ovf_n, inex_n;

    // Left shift is capped at exponent 1 so tiny results become subnormal instead of wrapping.
    always_comb begin
        lim = 32'(s2_exp) - 1;
        shl = (32'(s2_lz) < lim) ? 32'(s2_lz) : lim;
        if (s2_sum[SW]) begin
            m_n = s2_sum[SW:1] | SW'(s2_sum[0]);
            e_n = (EXP_W+1)'(s2_exp) + (EXP_W+1)'(1);
        end else begin
            m_n = s2_sum[SW-1:0] << shl;
            e_n = (EXP_W+1)'(32'(s2_exp) - shl);
        end
        lost   = |m_n[2:0];
        rnd_up = m_n[2] & (m_n[3] | m_n[1] | m_n[0]);
        mant_r = {1'b0, m_n[SW-1:3]} + (MAN_W+2)'(rnd_up);
        if (mant_r[MAN_W+1]) begin
            mant_f = mant_r[MAN_W+1:1];
            e_r    = e_n + (EXP_W+1)'(1);
        end else begin
            mant_f = mant_r[MAN_W:0];
            e_r    = e_n;
        end
        ovf    = mant_f[MAN_W] && (e_r >= {1'b0, EXP_ONES});
        exp_p  = mant_f[MAN_W] ? e_r[EXP_W-1:0] : '0;
        z_sign = (mant_f == '0) ? (!s2_sub && s2_sign) : s2_sign;
        res_n  = {z_sign, exp_p, mant_f[MAN_W-1:0]};
        inv_n  = 1'b0;
        ovf_n  = 1'b0;
        inex_n = lost;
        if (s2_spec) begin
            res_n  = s2_spec_res;
            inv_n  = s2_spec_inv;
            inex_n = 1'b0;
        end else if (ovf) begin
            res_n  = {s2_sign, EXP_ONES, MAN_W'(0)};
            ovf_n  = 1'b1;
            inex_n = 1'b1;
        end
    end

    // Output register; holds while downstream stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            inv_q       <= 1'b0;
            ovf_q       <= 1'b0;
            inex_q      <= 1'b0;
        end else if (advance) begin
            out_valid_q <= s2_valid;
            result_q    <= res_n;
            inv_q       <= inv_n;
            ovf_q       <= ovf_n;
            inex_q      <= inex_n;
        end
    end
endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Bench for fp_add_sub_pipe: directed vectors, random stream with backpressure, reset, FP16 build.
module tb_fp_add_sub_pipe;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fp_add_sub_pipe_if #(.W(32)) bus ();
    fp_add_sub_pipe_if #(.W(16)) hbus ();

    fp_add_sub_pipe dut (.clk(clk), .reset(reset), .bus(bus));
    fp_add_sub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .reset(reset), .bus(hbus));

    int vectors;
    int miscompares;
    logic [34:0] exp_q [$];   // {invalid, overflow, inexact, result}
    logic [31:0] specials [8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                                  32'h7FC00000, 32'h7F800001, 32'h00000001, 32'h7F7FFFFF};

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Exact magnitude in units of the smallest subnormal (2^-149).
    function automatic logic [299:0] mag(input logic [31:0] v);
        logic [299:0] sig;
        int e;
        sig = 300'(v[22:0]);
        e   = int'(v[30:23]);
        if (e == 0) e = 1;
        else sig[23] = 1'b1;
        return sig << (e - 1);
    endfunction

    // Reference: exact integer sum, then round-to-nearest-even into FP32.
    function automatic logic [34:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic sb, sign, nan_a, nan_b, inf_a, inf_b, up;
        logic [299:0] ma, mb, n, q, rem, half, one;
        int p, k;
        sb    = b[31] ^ s;
        nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        if (nan_a || nan_b)
            return {(nan_a && !a[22]) || (nan_b && !b[22]), 2'b00, 32'h7FC00000};
        if (inf_a && inf_b && (a[31] != sb)) return {3'b100, 32'h7FC00000};
        if (inf_a) return {3'b000, a};
        if (inf_b) return {3'b000, sb, b[30:0]};
        ma = mag(a);
        mb = mag(b);
        if (a[31] == sb) begin n = ma + mb; sign = a[31]; end
        else if (ma >= mb) begin n = ma - mb; sign = a[31]; end
        else begin n = mb - ma; sign = sb; end
        if (n == 0) return {3'b000, (a[31] == sb) ? a[31] : 1'b0, 31'h0};
        if (n[299:24] == 0) return {3'b000, sign, n[30:0]};
        p = 0;
        for (int i = 0; i < 300; i++) if (n[i]) p = i;
        one  = 300'(1);
        k    = p - 23;
        q    = n >> k;
        rem  = n & ((one << k) - one);
        half = one << (k - 1);
        up   = (rem > half) || ((rem == half) && q[0]);
        q    = q + 300'(up);
        if (q[24]) begin q = q >> 1; k++; end
        if (k + 1 >= 255) return {3'b011, sign, 8'hFF, 23'h0};
        return {2'b00, rem != 0, sign, 8'(k + 1), q[22:0]};
    endfunction

    // One cycle: drive at negedge, then check output against the scoreboard head.
    task automatic tick(input logic v, input logic [31:0] ta, input logic [31:0] tbv,
                        input logic ts, input logic rdy, output logic acc);
        logic [34:0] e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.a         = ta;
        bus.b         = tbv;
        bus.sub       = ts;
        bus.out_ready = rdy;
        #1;
        acc = v && bus.in_ready;
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'(bus.out_valid), 64'(0));
            end else begin
                e = exp_q[0];
                check("result", 64'(bus.result), 64'(e[31:0]));
                check("flags", 64'({bus.flag_invalid, bus.flag_overflow, bus.flag_inexact}),
                      64'(e[34:32]));
                if (rdy) void'(exp_q.pop_front());
            end
        end
        if (acc) exp_q.push_back(ref_add(ta, tbv, ts));
    endtask

    // Single op into an empty pipe: latency plus a hand-computed expected value.
    task automatic single(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                          input logic [31:0] want, input logic [2:0] want_f);
        logic acc;
        int n;
        tick(1'b1, ta, tbv, ts, 1'b1, acc);
        check("accept", 64'(acc), 64'(1));
        n = 0;
        do begin
            tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
            n++;
        end while (!bus.out_valid && n < 10);
        check("latency", 64'(n), 64'(3));
        check("dir_result", 64'(bus.result), 64'(want));
        check("dir_flags", 64'({bus.flag_invalid, bus.flag_overflow, bus.flag_inexact}), 64'(want_f));
    endtask

    // Run idle cycles until every expected result has been collected.
    task automatic drain();
        logic acc;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    endtask

    // Random operand pair, biased toward cancellation, subnormals, specials and overflow.
    task automatic gen(output logic [31:0] ga, output logic [31:0] gb, output logic gs);
        logic [31:0] r;
        int mode;
        ga   = $urandom;
        gb   = $urandom;
        gs   = 1'($urandom_range(0, 1));
        r    = $urandom;
        mode = int'($urandom_range(0, 5));
        case (mode)
            1: gb = {r[31], ga[30:23], r[22:0]};
            2: gb = {r[31], ga[30:23] - 8'(r[4:0]), r[22:0]};
            3: begin ga[30:23] = 8'(r[1:0]); gb[30:23] = 8'(r[3:2]); end
            4: gb = specials[r[2:0]];
            5: begin ga[30:23] = 8'hFE - 8'(r[0]); gb[30:23] = 8'hFE; end
            default: ;
        endcase
    endtask

    // FP16 build: one op with fixed expected result and flags.
    task automatic half_one(input logic [15:0] ta, input logic [15:0] tbv,
                            input logic [15:0] want, input logic [2:0] want_f);
        int n;
        @(negedge clk);
        hbus.in_valid  = 1'b1;
        hbus.a         = ta;
        hbus.b         = tbv;
        hbus.sub       = 1'b0;
        hbus.out_ready = 1'b1;
        #1;
        check("half_accept", 64'(hbus.in_ready), 64'(1));
        n = 0;
        do begin
            @(negedge clk);
            hbus.in_valid = 1'b0;
            #1;
            n++;
        end while (!hbus.out_valid && n < 10);
        check("half_latency", 64'(n), 64'(3));
        check("half_result", 64'(hbus.result), 64'(want));
        check("half_flags", 64'({hbus.flag_invalid, hbus.flag_overflow, hbus.flag_inexact}),
              64'(want_f));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] ga, gb;
        logic gs, acc, rdy;
        int j;
        vectors     = 0;
        miscompares = 0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b1;
        hbus.in_valid = 1'b0; hbus.a = '0; hbus.b = '0; hbus.sub = 1'b0; hbus.out_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'(0));
        check("reset_result", 64'(bus.result), 64'(0));
        check("reset_flags", 64'({bus.flag_invalid, bus.flag_overflow, bus.flag_inexact}), 64'(0));
        check("reset_half_valid", 64'(hbus.out_valid), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("reset_in_ready", 64'(bus.in_ready), 64'(1));

        // Directed vectors
        single(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
        single(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        single(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        single(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b001);
        single(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
        single(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
        single(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
        single(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000);
        single(32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 3'b000);
        single(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        single(32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 3'b000);
        single(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
        single(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000);

        // 20 back-to-back ops with pseudo-random out_ready, including a 5-cycle stall
        j = 0;
        for (int i = 0; i < 20; i++) begin
            gen(ga, gb, gs);
            do begin
                rdy = (j >= 4 && j < 9) ? 1'b0 : 1'($urandom_range(0, 1));
                tick(1'b1, ga, gb, gs, rdy, acc);
                j++;
            end while (!acc && j < 1000);
            check("stream_accept", 64'(acc), 64'(1));
        end
        drain();

        // Longer random run with input bubbles and mostly-ready output
        for (int i = 0; i < 300; i++) begin
            gen(ga, gb, gs);
            if ($urandom_range(0, 3) == 0) tick(1'b0, 32'h0, 32'h0, 1'b0, 1'($urandom_range(0, 1)), acc);
            j = 0;
            do begin
                tick(1'b1, ga, gb, gs, ($urandom_range(0, 3) != 0), acc);
                j++;
            end while (!acc && j < 100);
            check("rand_accept", 64'(acc), 64'(1));
        end
        drain();

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            gen(ga, gb, gs);
            tick(1'b1, ga, gb, gs, 1'b1, acc);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("prereset_out_valid", 64'(bus.out_valid), 64'(1));
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_result", 64'(bus.result), 64'(0));
        check("midrst_flags", 64'({bus.flag_invalid, bus.flag_overflow, bus.flag_inexact}), 64'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("postrst_in_ready", 64'(bus.in_ready), 64'(1));
        single(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);
        drain();

        // Half-precision build
        half_one(16'h3C00, 16'h3C00, 16'h4000, 3'b000);
        half_one(16'h7BFF, 16'h7BFF, 16'h7C00, 3'b011);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
